// File: rtl/pulse_train_gen_pkg.sv
// Shared types and defaults for the pulse-train generator.
// State codes are fixed so benches can decode them.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int unsigned LEN_W_DEF   = 8;
  localparam int unsigned COUNT_W_DEF = 4;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Phase length timer: loads max(len,1), counts down,
// flags the last cycle of the phase.
module phase_timer #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             en_i,
  output logic             expire_o
);

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [LEN_W-1:0] len_eff;

  assign len_eff  = (len_i == '0) ? ONE : len_i;
  assign expire_o = en_i && (cnt_q == ONE);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = len_eff;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse-train generator: FSM, shadowed settings and pulse counter;
// phase timing is delegated to phase_timer.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [LEN_W-1:0]   high_len,
  input  logic [LEN_W-1:0]   low_len,
  input  logic [COUNT_W-1:0] n_pulses,
  output logic               signal,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] pulse_cnt
);

  state_e             state_q, state_d;
  logic               signal_q, signal_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0]   hi_q, hi_d;
  logic [LEN_W-1:0]   lo_q, lo_d;
  logic [COUNT_W-1:0] n_q, n_d;
  logic               cont_q, cont_d;

  logic               tmr_clear;
  logic               tmr_load;
  logic [LEN_W-1:0]   tmr_len;
  logic               tmr_en;
  logic               expire;

  assign tmr_en = (state_q != ST_IDLE);

  phase_timer #(
    .LEN_W (LEN_W)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (tmr_clear),
    .load_i   (tmr_load),
    .len_i    (tmr_len),
    .en_i     (tmr_en),
    .expire_o (expire)
  );

  always_comb begin
    state_d   = state_q;
    signal_d  = signal_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    n_d       = n_q;
    cont_d    = cont_q;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_len   = hi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (continuous || n_pulses != '0) begin
            state_d  = ST_HIGH;
            signal_d = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = '0;
            hi_d     = high_len;
            lo_d     = low_len;
            n_d      = n_pulses;
            cont_d   = continuous;
            tmr_load = 1'b1;
            tmr_len  = high_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (stop) begin
          state_d   = ST_IDLE;
          signal_d  = 1'b0;
          busy_d    = 1'b0;
          tmr_clear = 1'b1;
        end else if (expire) begin
          state_d  = ST_LOW;
          signal_d = 1'b0;
          cnt_d    = cnt_q + COUNT_W'(1);
          tmr_load = 1'b1;
          tmr_len  = lo_q;
        end
      end
      ST_LOW: begin
        if (stop) begin
          state_d   = ST_IDLE;
          signal_d  = 1'b0;
          busy_d    = 1'b0;
          tmr_clear = 1'b1;
        end else if (expire) begin
          // Train always finishes on a low phase
          if (!cont_q && cnt_q == n_q) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            tmr_clear = 1'b1;
          end else begin
            state_d  = ST_HIGH;
            signal_d = 1'b1;
            tmr_load = 1'b1;
            tmr_len  = hi_q;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        signal_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      n_q      <= '0;
      cont_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      n_q      <= n_d;
      cont_q   <= cont_d;
    end
  end

  assign signal    = signal_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen; cycle k = state after the
// k-th rising edge counted from the edge that samples start.
module tb_pulse_train_gen;

  logic       clock      = 1'b0;
  logic       reset_n    = 1'b0;
  logic       start      = 1'b0;
  logic       stop       = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] high_len   = '0;
  logic [7:0] low_len    = '0;
  logic [3:0] n_pulses   = '0;
  logic       signal;
  logic       busy;
  logic       done;
  logic [3:0] pulse_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pulse_train_gen #(
    .LEN_W   (8),
    .COUNT_W (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .high_len   (high_len),
    .low_len    (low_len),
    .n_pulses   (n_pulses),
    .signal     (signal),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulse_cnt)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [7:0] hi, input logic [7:0] lo,
                        input logic [3:0] n, input logic c);
    high_len   = hi;
    low_len    = lo;
    n_pulses   = n;
    continuous = c;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    #3;
    got = {signal, busy, done, pulse_cnt};
    tests++;
    if (got !== 7'b0) begin
      fails++;
      $display("FAIL reset_hold got %b exp %b", got, 7'b0);
    end
    step();
    step();
    reset_n = 1'b1;
    step();
    got = {signal, busy, done, pulse_cnt};
    tests++;
    if (got !== 7'b0) begin
      fails++;
      $display("FAIL reset_release got %b exp %b", got, 7'b0);
    end
  endtask

  task automatic test_one_shot();
    logic [6:0] got, exp_v;
    logic [3:0] ec;
    launch(8'd4, 8'd4, 4'd3, 1'b0);
    for (int k = 0; k <= 25; k++) begin
      ec    = (k < 24) ? 4'((k + 4) / 8) : 4'd3;
      exp_v = {(k < 24) && ((k % 8) < 4), k < 24, k == 24, ec};
      got   = {signal, busy, done, pulse_cnt};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL one_shot k=%0d got %b exp %b", k, got, exp_v);
      end
      if (k < 25) step();
    end
  endtask

  task automatic test_min_len();
    logic [6:0] got, exp_v;
    logic [3:0] ec;
    launch(8'd0, 8'd0, 4'd2, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      ec    = (k >= 4) ? 4'd2 : 4'((k + 1) / 2);
      exp_v = {(k < 4) && ((k % 2) == 0), k < 4, k == 4, ec};
      got   = {signal, busy, done, pulse_cnt};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL min_len k=%0d got %b exp %b", k, got, exp_v);
      end
      if (k < 5) step();
    end
  endtask

  task automatic test_continuous();
    logic [6:0] got, exp_v;
    launch(8'd2, 8'd3, 4'd0, 1'b1);
    for (int k = 0; k <= 12; k++) begin
      exp_v = {(k % 5) < 2, 1'b1, 1'b0, 4'((k + 3) / 5)};
      got   = {signal, busy, done, pulse_cnt};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL continuous k=%0d got %b exp %b", k, got, exp_v);
      end
      if (k < 12) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    continuous = 1'b0;
    for (int k = 13; k <= 16; k++) begin
      exp_v = {1'b0, 1'b0, 1'b0, 4'd3};
      got   = {signal, busy, done, pulse_cnt};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL cont_stop k=%0d got %b exp %b", k, got, exp_v);
      end
      step();
    end
  endtask

  task automatic test_shadow();
    logic [6:0] got, exp_v;
    logic [3:0] ec;
    launch(8'd3, 8'd2, 4'd2, 1'b0);
    high_len = 8'd9;
    low_len  = 8'd7;
    n_pulses = 4'd5;
    for (int k = 0; k <= 11; k++) begin
      ec    = (k >= 10) ? 4'd2 : 4'((k + 2) / 5);
      exp_v = {(k < 10) && ((k % 5) < 3), k < 10, k == 10, ec};
      got   = {signal, busy, done, pulse_cnt};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL shadow k=%0d got %b exp %b", k, got, exp_v);
      end
      start = (k == 3);
      if (k < 11) step();
    end
    start    = 1'b0;
    n_pulses = 4'd1;
    start    = 1'b1;
    step();
    start    = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      ec    = (k >= 9) ? 4'd1 : 4'd0;
      exp_v = {k < 9, k < 16, k == 16, ec};
      got   = {signal, busy, done, pulse_cnt};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL shadow_next k=%0d got %b exp %b", k, got, exp_v);
      end
      if (k < 17) step();
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] got, exp_v;
    launch(8'd4, 8'd4, 4'd3, 1'b0);
    for (int k = 1; k <= 9; k++) step();
    exp_v = {1'b1, 1'b1, 1'b0, 4'd1};
    got   = {signal, busy, done, pulse_cnt};
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL mid_pre got %b exp %b", got, exp_v);
    end
    #2;
    reset_n = 1'b0;
    #1;
    got = {signal, busy, done, pulse_cnt};
    tests++;
    if (got !== 7'b0) begin
      fails++;
      $display("FAIL mid_async got %b exp %b", got, 7'b0);
    end
    step();
    reset_n = 1'b1;
    step();
    got = {signal, busy, done, pulse_cnt};
    tests++;
    if (got !== 7'b0) begin
      fails++;
      $display("FAIL mid_after got %b exp %b", got, 7'b0);
    end
    test_one_shot();
  endtask

  task automatic test_zero_n();
    logic [2:0] got, exp_v;
    launch(8'd4, 8'd4, 4'd0, 1'b0);
    for (int k = 0; k <= 4; k++) begin
      exp_v = {1'b0, 1'b0, k == 0};
      got   = {signal, busy, done};
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL zero_n k=%0d got %b exp %b", k, got, exp_v);
      end
      step();
    end
    n_pulses = 4'd3;
    start    = 1'b1;
    stop     = 1'b1;
    step();
    start    = 1'b0;
    stop     = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      got = {signal, busy, done};
      tests++;
      if (got !== 3'b0) begin
        fails++;
        $display("FAIL start_stop k=%0d got %b exp %b", k, got, 3'b0);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    step();
    test_min_len();
    step();
    test_continuous();
    test_shadow();
    step();
    test_reset_mid();
    step();
    test_zero_n();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
